// File: rtl/vector_fifo_writer_pkg.sv
// Shared types and helpers for the vector FIFO writer slice.
// The optional idle auto-flush is enabled by VECTOR_FIFO_WRITER_FLUSH_EN in the top level.
package vector_fifo_writer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Lane-index width; a single-lane vector still needs one index bit.
    function automatic int lane_idx_width(input int width_vector);
        return (width_vector > 1) ? $clog2(width_vector) : 1;
    endfunction

endpackage

// File: rtl/vector_lane_packer.sv
// Packs accepted scalar samples into lanes, zero-padding short vectors and flagging completion.
module vector_lane_packer #(
    parameter int WIDTH_VECTOR = 8,
    parameter int N            = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      accept,
    input  logic [N-1:0]              s_data,
    input  logic                      s_last,
    input  logic                      flush,
    input  logic                      clear,
    output logic                      complete,
    output logic [WIDTH_VECTOR*N-1:0] vector,
    output logic                      padded,
    output logic                      idx_nonzero
);
    import vector_fifo_writer_pkg::*;

    localparam int                IDX_W    = lane_idx_width(WIDTH_VECTOR);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH_VECTOR - 1);

    logic [IDX_W-1:0]          idx_r;
    logic [WIDTH_VECTOR*N-1:0] pack_r;
    logic [WIDTH_VECTOR*N-1:0] pack_next_s;
    logic                      pad_r;
    logic                      at_last_s;
    logic                      complete_s;
    logic                      padded_s;

    assign at_last_s = (idx_r == LAST_IDX);

    // Pack contents including the sample accepted this cycle.
    always_comb begin
        pack_next_s = pack_r;
        if (accept) begin
            pack_next_s[idx_r*N +: N] = s_data;
        end else begin
            pack_next_s = pack_r;
        end
    end

    // Completion on the last lane, on s_last, or on a forced flush of a partial vector.
    always_comb begin
        complete_s = 1'b0;
        padded_s   = pad_r;
        if (accept) begin
            complete_s = at_last_s || s_last;
            padded_s   = !at_last_s;
        end else if (flush && (idx_r != {IDX_W{1'b0}})) begin
            complete_s = 1'b1;
            padded_s   = 1'b1;
        end else begin
            complete_s = 1'b0;
            padded_s   = pad_r;
        end
    end

    // Lane index: wraps to lane 0 whenever a vector completes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (complete_s) begin
            idx_r <= {IDX_W{1'b0}};
        end else if (accept) begin
            idx_r <= idx_r + IDX_W'(1);
        end else begin
            idx_r <= idx_r;
        end
    end

    // Pack register and padding flag; a hand-over clears both so unused lanes read as zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pack_r <= {(WIDTH_VECTOR*N){1'b0}};
            pad_r  <= 1'b0;
        end else if (clear) begin
            pack_r <= {(WIDTH_VECTOR*N){1'b0}};
            pad_r  <= 1'b0;
        end else begin
            pack_r <= accept ? pack_next_s : pack_r;
            pad_r  <= complete_s ? padded_s : pad_r;
        end
    end

    assign complete    = complete_s;
    assign vector      = pack_next_s;
    assign padded      = padded_s;
    assign idx_nonzero = (idx_r != {IDX_W{1'b0}});

endmodule

// File: rtl/vector_fifo_writer.sv
// Producer front end: packs samples into lane vectors and writes them to the vector FIFO.
// Optional idle auto-flush of partial vectors: define VECTOR_FIFO_WRITER_FLUSH_EN.
module vector_fifo_writer #(
    parameter int WIDTH_VECTOR  = 8,
    parameter int N             = 32,
    parameter int CNT_W         = 16,
    parameter int FLUSH_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [N-1:0]              s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    input  logic                      fifo_full,
    output logic [WIDTH_VECTOR*N-1:0] fifo_wdata,
    output logic                      fifo_winc,
    output logic [CNT_W-1:0]          vec_count,
    output logic [CNT_W-1:0]          partial_count,
    output logic                      busy
);
    import vector_fifo_writer_pkg::*;

    state_t                    state_r;
    state_t                    state_n_s;
    logic                      out_valid_r;
    logic [WIDTH_VECTOR*N-1:0] out_data_r;
    logic                      out_pad_r;
    logic [CNT_W-1:0]          vec_count_r;
    logic [CNT_W-1:0]          partial_count_r;

    logic                      winc_s;
    logic                      accept_s;
    logic                      slot_free_s;
    logic                      load_s;
    logic                      clear_s;
    logic                      flush_s;
    logic                      complete_s;
    logic                      padded_s;
    logic                      idx_nonzero_s;
    logic [WIDTH_VECTOR*N-1:0] vector_s;

    assign winc_s      = out_valid_r && !fifo_full;
    assign accept_s    = s_valid && (state_r == FILL);
    assign slot_free_s = !out_valid_r || winc_s;

    vector_lane_packer #(
        .WIDTH_VECTOR (WIDTH_VECTOR),
        .N            (N)
    ) u_packer (
        .clk         (clk),
        .rstn        (rstn),
        .accept      (accept_s),
        .s_data      (s_data),
        .s_last      (s_last),
        .flush       (flush_s),
        .clear       (clear_s),
        .complete    (complete_s),
        .vector      (vector_s),
        .padded      (padded_s),
        .idx_nonzero (idx_nonzero_s)
    );

`ifdef VECTOR_FIFO_WRITER_FLUSH_EN
    localparam int               IDLE_W    = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_cnt_r;
    logic              idle_s;

    assign idle_s  = (state_r == FILL) && idx_nonzero_s && !accept_s;
    assign flush_s = idle_s && (idle_cnt_r == IDLE_LAST);

    // Idle timer: the flush fires on the FLUSH_TIMEOUT-th consecutive idle cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else if (!idle_s || flush_s) begin
            idle_cnt_r <= {IDLE_W{1'b0}};
        end else begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
        end
    end
`else
    assign flush_s = 1'b0;
`endif

    // Next state and hand-over of a completed vector to the output slot.
    always_comb begin
        state_n_s = state_r;
        load_s    = 1'b0;
        clear_s   = 1'b0;
        case (state_r)
            FILL: begin
                if (complete_s) begin
                    if (slot_free_s) begin
                        load_s  = 1'b1;
                        clear_s = 1'b1;
                    end else begin
                        state_n_s = WAIT;
                    end
                end else begin
                    state_n_s = FILL;
                end
            end
            WAIT: begin
                if (winc_s) begin
                    load_s    = 1'b1;
                    clear_s   = 1'b1;
                    state_n_s = FILL;
                end else begin
                    state_n_s = WAIT;
                end
            end
            default: begin
                state_n_s = FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= FILL;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Output slot: a reload on the write edge keeps it valid, otherwise a write empties it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {(WIDTH_VECTOR*N){1'b0}};
            out_pad_r   <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= vector_s;
            out_pad_r   <= padded_s;
        end else if (winc_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_pad_r   <= out_pad_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_pad_r   <= out_pad_r;
        end
    end

    // Write counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vec_count_r     <= {CNT_W{1'b0}};
            partial_count_r <= {CNT_W{1'b0}};
        end else if (winc_s) begin
            vec_count_r     <= vec_count_r + CNT_W'(1);
            partial_count_r <= out_pad_r ? (partial_count_r + CNT_W'(1)) : partial_count_r;
        end else begin
            vec_count_r     <= vec_count_r;
            partial_count_r <= partial_count_r;
        end
    end

    assign s_ready       = (state_r == FILL);
    assign fifo_winc     = winc_s;
    assign fifo_wdata    = out_data_r;
    assign vec_count     = vec_count_r;
    assign partial_count = partial_count_r;
    assign busy          = out_valid_r || idx_nonzero_s || (state_r == WAIT);

endmodule

// File: tb/tb_vector_fifo_writer.sv
// Self-checking bench for vector_fifo_writer: a lane model fills an expected-vector queue,
// a negedge monitor pops it on every FIFO write, and per-scenario tasks check control and counters.
module tb_vector_fifo_writer;

    localparam int WV   = 8;
    localparam int NB   = 32;
    localparam int CW   = 16;
    localparam int VW   = WV * NB;

    typedef struct {
        logic [VW-1:0] data;
        bit            pad;
    } exp_t;

    logic          clk;
    logic          rstn;
    logic [NB-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          fifo_full;
    logic [VW-1:0] fifo_wdata;
    logic          fifo_winc;
    logic [CW-1:0] vec_count;
    logic [CW-1:0] partial_count;
    logic          busy;

    int            n_checks;
    int            n_pass;
    int            n_stalls;
    int            m_idx;
    int            m_vec_total;
    int            m_part_total;
    logic [NB-1:0] m_lanes [WV];
    exp_t          exp_q [$];
    bit            tog_done;

    vector_fifo_writer #(
        .WIDTH_VECTOR  (WV),
        .N             (NB),
        .CNT_W         (CW),
        .FLUSH_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .fifo_full     (fifo_full),
        .fifo_wdata    (fifo_wdata),
        .fifo_winc     (fifo_winc),
        .vec_count     (vec_count),
        .partial_count (partial_count),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_clear();
        for (int l = 0; l < WV; l++) m_lanes[l] = '0;
        m_idx = 0;
    endfunction

    function automatic void model_complete();
        exp_t e;
        for (int l = 0; l < WV; l++) e.data[l*NB +: NB] = m_lanes[l];
        e.pad = (m_idx < WV);
        exp_q.push_back(e);
        m_vec_total++;
        if (e.pad) m_part_total++;
        model_clear();
    endfunction

    function automatic void model_accept(input logic [NB-1:0] d, input bit last);
        m_lanes[m_idx] = d;
        m_idx++;
        if (m_idx == WV || last) model_complete();
    endfunction

    // Scoreboard: every FIFO write must match the oldest expected vector.
    always @(negedge clk) begin
        exp_t e;
        if (rstn === 1'b1 && fifo_winc === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write wdata=%h expected no write", fifo_wdata);
            end else begin
                e = exp_q.pop_front();
                if (fifo_wdata !== e.data)
                    $display("FAIL write_data got=%h exp=%h", fifo_wdata, e.data);
                else
                    n_pass++;
            end
        end
    end

    // Offers one sample and returns one cycle after it is accepted (posedge + 1).
    task automatic send(input logic [NB-1:0] d, input bit last);
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                model_accept(d, last);
                @(posedge clk);
                #1;
                return;
            end
            n_stalls++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        $display("FAIL send_timeout got s_ready=%b exp 1 within 200 cycles", s_ready);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain_timeout got %0d pending exp 0", exp_q.size());
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_data    = '0;
        fifo_full = 1'b0;
        rstn      = 1'b0;
        exp_q.delete();
        model_clear();
        m_vec_total  = 0;
        m_part_total = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 6;
        if (fifo_winc !== 1'b0) $display("FAIL reset_winc got=%b exp=0", fifo_winc); else n_pass++;
        if (fifo_wdata !== '0) $display("FAIL reset_wdata got=%h exp=0", fifo_wdata); else n_pass++;
        if (vec_count !== '0) $display("FAIL reset_vec_count got=%0d exp=0", vec_count); else n_pass++;
        if (partial_count !== '0) $display("FAIL reset_partial got=%0d exp=0", partial_count); else n_pass++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        if (s_ready !== 1'b1) $display("FAIL reset_s_ready got=%b exp=1", s_ready); else n_pass++;
    endtask

    task automatic test_full_vector();
        n_stalls = 0;
        for (int i = 1; i <= WV; i++) send(NB'(i), 1'b0);
        s_valid = 1'b0;
        n_checks += 2;
        if (n_stalls != 0) $display("FAIL full_s_ready_stalls got=%0d exp=0", n_stalls); else n_pass++;
        if (fifo_winc !== 1'b1) $display("FAIL full_winc_latency got=%b exp=1", fifo_winc); else n_pass++;
        @(posedge clk);
        #1;
        n_checks += 2;
        if (fifo_winc !== 1'b0) $display("FAIL full_winc_single got=%b exp=0", fifo_winc); else n_pass++;
        if (vec_count !== CW'(m_vec_total)) $display("FAIL full_vec_count got=%0d exp=%0d", vec_count, m_vec_total); else n_pass++;
        drain();
        n_checks++;
        if (partial_count !== CW'(m_part_total)) $display("FAIL full_partial got=%0d exp=%0d", partial_count, m_part_total); else n_pass++;
    endtask

    task automatic test_partial();
        send(32'h0000_000A, 1'b0);
        send(32'h0000_000B, 1'b0);
        send(32'h0000_000C, 1'b1);
        s_valid = 1'b0;
        drain();
        n_checks += 2;
        if (partial_count !== CW'(m_part_total)) $display("FAIL partial_count got=%0d exp=%0d", partial_count, m_part_total); else n_pass++;
        if (busy !== 1'b0) $display("FAIL partial_idle_busy got=%b exp=0", busy); else n_pass++;
        send(32'h0000_0055, 1'b1);
        s_valid = 1'b0;
        drain();
        n_checks++;
        if (partial_count !== CW'(m_part_total)) $display("FAIL single_lane_partial got=%0d exp=%0d", partial_count, m_part_total); else n_pass++;
    endtask

    task automatic test_backpressure();
        fifo_full = 1'b1;
        for (int i = 1; i <= 2 * WV; i++) send(NB'(i), 1'b0);
        s_valid = 1'b0;
        n_checks += 3;
        if (s_ready !== 1'b0) $display("FAIL bp_wait_s_ready got=%b exp=0", s_ready); else n_pass++;
        if (busy !== 1'b1) $display("FAIL bp_busy got=%b exp=1", busy); else n_pass++;
        if (fifo_winc !== 1'b0) $display("FAIL bp_winc_while_full got=%b exp=0", fifo_winc); else n_pass++;
        fifo_full = 1'b0;
        #1;
        n_checks++;
        if (fifo_winc !== 1'b1) $display("FAIL bp_first_winc got=%b exp=1", fifo_winc); else n_pass++;
        @(posedge clk);
        #1;
        n_checks += 2;
        if (fifo_winc !== 1'b1) $display("FAIL bp_second_winc got=%b exp=1", fifo_winc); else n_pass++;
        if (s_ready !== 1'b1) $display("FAIL bp_ready_after_winc got=%b exp=1", s_ready); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (fifo_winc !== 1'b0) $display("FAIL bp_winc_done got=%b exp=0", fifo_winc); else n_pass++;
        drain();
        n_checks++;
        if (vec_count !== CW'(m_vec_total)) $display("FAIL bp_vec_count got=%0d exp=%0d", vec_count, m_vec_total); else n_pass++;
    endtask

    task automatic test_toggle_full();
        int start_vec;
        start_vec = m_vec_total;
        tog_done  = 1'b0;
        fork
            begin
                while (!tog_done) begin
                    @(posedge clk);
                    #1;
                    fifo_full = !fifo_full;
                end
            end
            begin
                for (int i = 0; i < 8 * WV; i++) send($urandom, 1'b0);
                s_valid  = 1'b0;
                tog_done = 1'b1;
            end
        join
        fifo_full = 1'b0;
        drain();
        n_checks += 2;
        if (m_vec_total - start_vec != 8) $display("FAIL toggle_model_vectors got=%0d exp=8", m_vec_total - start_vec); else n_pass++;
        if (vec_count !== CW'(m_vec_total)) $display("FAIL toggle_vec_count got=%0d exp=%0d", vec_count, m_vec_total); else n_pass++;
    endtask

    task automatic test_reset_mid();
        fifo_full = 1'b1;
        for (int i = 1; i <= WV + 5; i++) send(NB'(i * 3), 1'b0);
        s_valid   = 1'b0;
        fifo_full = 1'b0;
        #1;
        n_checks++;
        if (fifo_winc !== 1'b1) $display("FAIL rst_pre_winc got=%b exp=1", fifo_winc); else n_pass++;
        #1;
        rstn = 1'b0;
        exp_q.delete();
        model_clear();
        m_vec_total  = 0;
        m_part_total = 0;
        #1;
        n_checks += 5;
        if (fifo_winc !== 1'b0) $display("FAIL rst_async_winc got=%b exp=0", fifo_winc); else n_pass++;
        if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        if (vec_count !== '0) $display("FAIL rst_vec_count got=%0d exp=0", vec_count); else n_pass++;
        if (partial_count !== '0) $display("FAIL rst_partial got=%0d exp=0", partial_count); else n_pass++;
        if (fifo_wdata !== '0) $display("FAIL rst_wdata got=%h exp=0", fifo_wdata); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= WV; i++) send(NB'(100 + i), 1'b0);
        s_valid = 1'b0;
        drain();
        n_checks++;
        if (vec_count !== CW'(m_vec_total)) $display("FAIL rst_restart_count got=%0d exp=%0d", vec_count, m_vec_total); else n_pass++;
    endtask

    task automatic test_flush();
        send(32'h0000_0011, 1'b0);
        send(32'h0000_0022, 1'b0);
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (fifo_winc !== 1'b0) $display("FAIL flush_early got=%b exp=0", fifo_winc); else n_pass++;
        @(posedge clk);
        #1;
`ifdef VECTOR_FIFO_WRITER_FLUSH_EN
        model_complete();
        n_checks++;
        if (fifo_winc !== 1'b1) $display("FAIL flush_winc got=%b exp=1", fifo_winc); else n_pass++;
`else
        repeat (10) @(posedge clk);
        #1;
        n_checks += 2;
        if (fifo_winc !== 1'b0) $display("FAIL no_flush_winc got=%b exp=0", fifo_winc); else n_pass++;
        if (busy !== 1'b1) $display("FAIL no_flush_busy got=%b exp=1", busy); else n_pass++;
        send(32'h0000_0033, 1'b1);
        s_valid = 1'b0;
`endif
        drain();
        n_checks += 2;
        if (partial_count !== CW'(m_part_total)) $display("FAIL flush_partial got=%0d exp=%0d", partial_count, m_part_total); else n_pass++;
        if (vec_count !== CW'(m_vec_total)) $display("FAIL flush_vec_count got=%0d exp=%0d", vec_count, m_vec_total); else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_stalls  = 0;
        tog_done  = 1'b0;
        rstn      = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_data    = '0;
        fifo_full = 1'b0;
        model_clear();
        m_vec_total  = 0;
        m_part_total = 0;
        test_reset();
        test_full_vector();
        test_partial();
        test_backpressure();
        test_toggle_full();
        test_reset_mid();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vector_fifo_writer.md
Name: vector_fifo_writer

Overview:
- Producer-side front end for the core's vector input FIFO, driving the FIFO's write port (fifo_wdata, fifo_winc, fifo_full).
- Accepts a stream of scalar N-bit samples over a valid/ready handshake and packs WIDTH_VECTOR samples into one lane vector.
- Writes each vector into the FIFO only while fifo_full is low.
- Runs entirely in the FIFO write-clock domain; clk is that domain's clock, and the core wires it to fifo_wclk.

Parameters:
- WIDTH_VECTOR, 8: lanes per vector; power of 2.
- N, 32: bits per lane/sample.
- CNT_W, 16: width of the status counters.
- FLUSH_TIMEOUT, 255: idle cycles before auto-flush (optional feature only); must be ≥1.

Ports:
- clk, input, 1: write-domain clock.
- rstn, input, 1: reset, asynchronous, active-low.
- s_data, input, N: sample in.
- s_valid, input, 1: sample valid.
- s_last, input, 1: close the current vector after this sample.
- s_ready, output, 1: block accepts a sample this cycle.
- fifo_full, input, 1: FIFO full (write domain).
- fifo_wdata, output, WIDTH_VECTOR*N: packed vector; lane i = bits [i*N +: N].
- fifo_winc, output, 1: write strobe.
- vec_count, output, CNT_W: vectors written.
- partial_count, output, CNT_W: vectors written with zero padding.
- busy, output, 1: pack register or output register non-empty.

Behaviour:
- Reset (rstn low, async): state=FILL, lane index=0, pack register=0, out_valid=0. Resulting outputs: fifo_wdata=0, fifo_winc=0, vec_count=0, partial_count=0, busy=0, s_ready=1.
- Accept: a sample is accepted on a cycle with s_valid&&s_ready. It is written to pack lane[idx], and idx increments.
- Lane order: the first sample of a vector goes to lane 0.
- Vector complete: the accepted sample is at idx=WIDTH_VECTOR-1, or s_last=1 on the accepted sample.
  - On completion, lanes above the last written lane are zero.
  - idx returns to 0.
- Output register: holds one vector (out_valid, out_data).
  - fifo_winc = out_valid && !fifo_full (combinational from registers and fifo_full).
  - fifo_wdata = out_data.
  - out_valid clears on a cycle with fifo_winc=1 unless it is reloaded on the same edge.
- FSM:
  - FILL:
    - s_ready=1.
    - On completion, if the output slot is free (!out_valid || fifo_winc this cycle), the completed vector loads out_data on that edge; state stays FILL.
    - Otherwise the completed vector stays in the pack register and state goes to WAIT.
  - WAIT:
    - s_ready=0.
    - On a cycle with fifo_winc=1, the pack register moves to out_data, the pack register clears, and state returns to FILL.
- Latency: last lane accepted at cycle t → fifo_winc high at t+1 if fifo_full=0.
- Throughput: one sample per cycle sustained; one vector every WIDTH_VECTOR cycles.
- No FIFO writes are lost or duplicated while fifo_full toggles. fifo_wdata is stable while fifo_winc is low and out_valid is high.
- vec_count increments on each fifo_winc. partial_count increments on each fifo_winc of a padded vector.
  - Padding is recorded with a sideband flag beside out_data.
  - Both counters wrap modulo 2^CNT_W.
- s_last when idx=0 and the sample is accepted: produces a 1-lane vector, padded. s_last is ignored when s_valid is low.
- busy = out_valid || idx!=0 || state==WAIT.
- Reset mid-operation: any partial and buffered vectors are discarded and never written. fifo_winc drops to 0 asynchronously.

Optional Feature:
- Macro: VECTOR_FIFO_WRITER_FLUSH_EN.
- Defined:
  - An idle counter counts FILL cycles with idx!=0 and no accept.
  - When the counter reaches FLUSH_TIMEOUT, the partial vector completes exactly as if s_last had been given: zero padding, counted in partial_count.
  - The counter clears on any accept, on completion, and on reset.
- Undefined: no counter logic; a partial vector waits indefinitely for further samples or s_last.

Decomposition:
- Package vector_fifo_writer_pkg:
  - state typedef enum {FILL, WAIT}.
  - Function computing the lane-index width, $clog2(WIDTH_VECTOR).
- Sub-module vector_lane_packer:
  - Contents: pack register, lane index, zero-padding, completion detect.
  - Ports: accept, s_data, s_last, clear; outputs complete, vector, padded.
  - The top level holds the FSM, the output register, the counters and the flush timer.

Test Plan:
- Samples 1..8 back-to-back, s_last=0 on all, fifo_full=0 → s_ready stays 1; fifo_winc for one cycle, the cycle after the 8th accept; lanes 0..7 = 1..8; vec_count=1; partial_count=0.
- Samples 0xA, 0xB, 0xC with s_last on 0xC → fifo_wdata lanes = {0xA,0xB,0xC,0,0,0,0,0}; partial_count=1; the next sample lands in lane 0.
- fifo_full=1, 16 samples streamed → after the 16th accept s_ready=0 and state=WAIT. Release fifo_full → fifo_winc on two consecutive cycles with vectors 1..8 then 9..16; s_ready=1 the cycle after the first winc.
- fifo_full toggled every cycle during 64 samples → exactly 8 writes, in order, matching a reference model; vec_count=8.
- 5 samples, then rstn pulsed low mid-cycle → fifo_winc=0 immediately; no write for those samples; counters=0; a new stream restarts at lane 0.
- With VECTOR_FIFO_WRITER_FLUSH_EN and FLUSH_TIMEOUT=4: 2 samples then idle → padded write on the 4th idle cycle boundary; partial_count=1. Without the macro → no write.
